knips_core_p: RTL and testbench

//  Parametrised successor of the fixed 8-bit KNIPS datapath top. PC, 8-entry reg file,
//  ALU, carry reg and control FSM sit in one core. Instruction and data memories are external:
//  - imem is combinational.
//  - dmem uses a req/ack handshake, so memory ops take a variable number of cycles.

---
 rtl/knips_pkg.sv | 28 ++
 rtl/knips_if.sv | 24 ++
 rtl/knips_alu_p.sv | 39 +++
 rtl/knips_core_p.sv | 185 ++++++++++++++++++
 tb/tb_knips_core_p.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/knips_pkg.sv
// Shared opcode, system sub-op and FSM state definitions for the KNIPS core.
package knips_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_XOR = 3'b010,
    OP_SHL = 3'b011,
    OP_LD  = 3'b100,
    OP_ST  = 3'b101,
    OP_BZ  = 3'b110,
    OP_SYS = 3'b111
  } opcode_t;

  // Sub-ops carried in the imm field of OP_SYS; anything else is a NOP.
  localparam logic [2:0] SUB_HALT = 3'b000;
  localparam logic [2:0] SUB_CLC  = 3'b001;
  localparam logic [2:0] SUB_SETC = 3'b010;

  localparam int NREGS = 8;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    MEM  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/knips_if.sv
// Instruction fetch and data memory req/ack bus between the KNIPS core and its memories.
interface knips_if #(
  parameter int DW  = 8,
  parameter int PCW = 10
);
  logic [PCW-1:0] imem_addr;
  logic [8:0]     imem_data;
  logic           dmem_req;
  logic           dmem_we;
  logic [DW-1:0]  dmem_addr;
  logic [DW-1:0]  dmem_wdata;
  logic [DW-1:0]  dmem_rdata;
  logic           dmem_ack;

  modport master (
    output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_data, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_data, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/knips_alu_p.sv
// Combinational KNIPS ALU: ADD/ADC/XOR/SHL with carry; zero_o flags operand a for BZ.
module knips_alu_p
  import knips_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          sc_i,
  input  opcode_t       op_i,
  output logic [DW-1:0] y_o,
  output logic          sc_o,
  output logic          zero_o
);
  localparam int SW = DW + 1;

  logic [DW:0] sum;

  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i} + ((op_i == OP_ADC) ? SW'(sc_i) : SW'(0));
    y_o  = a_i;
    sc_o = sc_i;
    case (op_i)
      OP_ADD, OP_ADC: begin
        y_o  = sum[DW-1:0];
        sc_o = sum[DW];
      end
      OP_XOR: y_o = a_i ^ b_i;
      OP_SHL: begin
        y_o  = {a_i[DW-2:0], sc_i};
        sc_o = a_i[DW-1];
      end
      default: ;
    endcase
  end

  assign zero_o = (a_i == '0);

endmodule

// File: rtl/knips_core_p.sv
// KNIPS core: PC, 8-entry register file, carry, RUN/MEM/DONE control and optional
// perf counters (built only when KNIPS_PERF_CNT_EN is defined, else tied to 0).
module knips_core_p
  import knips_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PCW = 10,
  parameter int CTW = 16
) (
  input  logic           clk,
  input  logic           start_n,
  knips_if.master        bus,
  output logic           halt_o,
  output logic [CTW-1:0] cycle_ct_o,
  output logic [CTW-1:0] instr_ct_o
);
  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           sc_q, sc_d;
  logic           halt_q, halt_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [2:0]     ra_q, ra_d;

  logic [DW-1:0]  regs_q [NREGS];
  logic           rf_we;
  logic [2:0]     rf_idx;
  logic [DW-1:0]  rf_wdata;

  logic [8:0]     instr;
  opcode_t        op;
  logic [2:0]     ra, rb;
  logic [DW-1:0]  a_val, b_val, alu_y;
  logic           alu_sc, alu_zero;
  logic [PCW-1:0] br_off;

  assign instr  = bus.imem_data;
  assign op     = opcode_t'(instr[8:6]);
  assign ra     = instr[5:3];
  assign rb     = instr[2:0];
  assign a_val  = regs_q[ra];
  assign b_val  = regs_q[rb];
  assign br_off = {{(PCW-3){instr[2]}}, instr[2:0]};

  knips_alu_p #(.DW(DW)) u_alu (
    .a_i    (a_val),
    .b_i    (b_val),
    .sc_i   (sc_q),
    .op_i   (op),
    .y_o    (alu_y),
    .sc_o   (alu_sc),
    .zero_o (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sc_d     = sc_q;
    halt_d   = halt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ra_d     = ra_q;
    rf_we    = 1'b0;
    rf_idx   = ra;
    rf_wdata = alu_y;
    case (state_q)
      RUN: begin
        case (op)
          OP_ADD, OP_ADC, OP_XOR, OP_SHL: begin
            rf_we = 1'b1;
            sc_d  = alu_sc;
            pc_d  = pc_q + PCW'(1);
          end
          OP_BZ: pc_d = alu_zero ? pc_q + br_off : pc_q + PCW'(1);
          OP_LD, OP_ST: begin
            // Operands are captured here so the bus stays stable for the whole wait.
            ra_d    = ra;
            addr_d  = b_val;
            wdata_d = a_val;
            we_d    = (op == OP_ST);
            req_d   = 1'b1;
            state_d = MEM;
          end
          default: begin
            pc_d = pc_q + PCW'(1);
            case (instr[2:0])
              SUB_HALT: begin
                pc_d    = pc_q;
                halt_d  = 1'b1;
                state_d = DONE;
              end
              SUB_CLC:  sc_d = 1'b0;
              SUB_SETC: sc_d = 1'b1;
              default:  ;
            endcase
          end
        endcase
      end
      MEM: begin
        if (bus.dmem_ack) begin
          rf_we    = !we_q;
          rf_idx   = ra_q;
          rf_wdata = bus.dmem_rdata;
          pc_d     = pc_q + PCW'(1);
          req_d    = 1'b0;
          state_d  = RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      state_q <= RUN;
      pc_q    <= '0;
      sc_q    <= 1'b0;
      halt_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      halt_q  <= halt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ra_q    <= ra_d;
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    always_ff @(posedge clk or negedge start_n) begin
      if (!start_n) begin
        regs_q[gi] <= '0;
      end else if (rf_we && (rf_idx == 3'(gi))) begin
        regs_q[gi] <= rf_wdata;
      end
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign halt_o         = halt_q;

`ifdef KNIPS_PERF_CNT_EN
  logic           retire;
  logic [CTW-1:0] cycle_q, cycle_d, instr_q, instr_d;

  assign retire  = ((state_q == RUN) && (op != OP_LD) && (op != OP_ST)) ||
                   ((state_q == MEM) && bus.dmem_ack);
  // Both counters saturate rather than wrap.
  assign cycle_d = (!halt_q && (cycle_q != '1)) ? cycle_q + CTW'(1) : cycle_q;
  assign instr_d = (retire && (instr_q != '1)) ? instr_q + CTW'(1) : instr_q;

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_ct_o = cycle_q;
  assign instr_ct_o = instr_q;
`else
  assign cycle_ct_o = '0;
  assign instr_ct_o = '0;
`endif

endmodule

// File: tb/tb_knips_core_p.sv
// Directed self-checking bench for knips_core_p with a combinational imem and req/ack dmem model.
module tb_knips_core_p;
  import knips_pkg::*;

  localparam int DW  = 8;
  localparam int PCW = 10;
  localparam int CTW = 4;
`ifdef KNIPS_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [8:0] NOP = 9'b111_000_011;

  logic clk = 1'b0;
  logic start_n = 1'b0;
  always #5 clk = ~clk;

  knips_if #(.DW(DW), .PCW(PCW)) bus ();
  logic           halt;
  logic [CTW-1:0] cycle_ct, instr_ct;

  knips_core_p #(.DW(DW), .PCW(PCW), .CTW(CTW)) dut (
    .clk        (clk),
    .start_n    (start_n),
    .bus        (bus),
    .halt_o     (halt),
    .cycle_ct_o (cycle_ct),
    .instr_ct_o (instr_ct)
  );

  logic [8:0]    imem [0:(1<<PCW)-1];
  logic [DW-1:0] dmem [0:255];
  int            ack_wait = 0;
  int            wcnt = 0;
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = '0, pre_data = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  assign bus.dmem_ack   = bus.dmem_req && (wcnt == ack_wait);

  always @(posedge clk) begin
    if (pre_we) dmem[pre_addr] <= pre_data;
    else if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    if (bus.dmem_req && !bus.dmem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb);
    return {op, ra, rb};
  endfunction

  task automatic enter_reset();
    start_n = 1'b0;
    ack_wait = 0;
    for (int i = 0; i < (1 << PCW); i++) imem[i] = NOP;
    repeat (2) @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    start_n = 1'b1;
  endtask

  task automatic test_reset();
    enter_reset();
    n_checks++;
    if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.imem_addr); end
    n_checks++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== 18'd0) begin
      n_fail++; $display("FAIL reset_dmem_bus: got req=%b we=%b addr=%0h wdata=%0h want all 0",
                         bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata);
    end
    n_checks++;
    if ({halt, cycle_ct, instr_ct} !== 9'd0) begin
      n_fail++; $display("FAIL reset_halt_ct: got halt=%b cyc=%0d ins=%0d want 0", halt, cycle_ct, instr_ct);
    end
    $display("test_reset: done");
  endtask

  task automatic test_add_bz();
    enter_reset();
    poke(8'h00, 8'h0F);
    poke(8'h01, 8'hF1);
    imem[0] = enc(OP_LD, 3'd1, 3'd0);
    imem[1] = enc(OP_SYS, 3'd0, SUB_SETC);
    imem[2] = enc(OP_ADC, 3'd6, 3'd6);
    imem[3] = enc(OP_LD, 3'd2, 3'd6);
    imem[4] = enc(OP_ADD, 3'd1, 3'd2);
    imem[5] = enc(OP_BZ, 3'd1, 3'd2);
    imem[6] = enc(OP_SYS, 3'd0, SUB_HALT);
    release_reset();
    repeat (7) @(negedge clk);
    n_checks++;
    if (dut.regs_q[2] !== 8'hF1) begin n_fail++; $display("FAIL ld_preload: got %0h want f1", dut.regs_q[2]); end
    n_checks++;
    if (dut.regs_q[1] !== 8'h00) begin n_fail++; $display("FAIL add_sum: got %0h want 00", dut.regs_q[1]); end
    n_checks++;
    if (dut.sc_q !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b want 1", dut.sc_q); end
    n_checks++;
    if (bus.imem_addr !== 10'd5) begin n_fail++; $display("FAIL pc_before_bz: got %0d want 5", bus.imem_addr); end
    @(negedge clk);
    n_checks++;
    if (bus.imem_addr !== 10'd7) begin n_fail++; $display("FAIL bz_taken: got %0d want 7", bus.imem_addr); end
    $display("test_add_bz: done");
  endtask

  task automatic test_store_load();
    int req_cnt;
    logic [PCW-1:0] pc_stall;
    enter_reset();
    poke(8'h00, 8'h20);
    poke(8'h01, 8'hA5);
    poke(8'h20, 8'h00);
    imem[0] = enc(OP_LD, 3'd4, 3'd0);
    imem[1] = enc(OP_SYS, 3'd0, SUB_SETC);
    imem[2] = enc(OP_ADC, 3'd6, 3'd6);
    imem[3] = enc(OP_LD, 3'd3, 3'd6);
    imem[4] = enc(OP_ST, 3'd3, 3'd4);
    imem[5] = enc(OP_LD, 3'd5, 3'd4);
    release_reset();
    repeat (6) @(negedge clk);
    ack_wait = 3;
    req_cnt  = 0;
    pc_stall = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.dmem_req) req_cnt++;
      if (i == 3) pc_stall = bus.imem_addr;
    end
    n_checks++;
    if (req_cnt !== 4) begin n_fail++; $display("FAIL st_req_cycles: got %0d want 4", req_cnt); end
    n_checks++;
    if (pc_stall !== 10'd4) begin n_fail++; $display("FAIL st_pc_stall: got %0d want 4", pc_stall); end
    n_checks++;
    if (bus.imem_addr !== 10'd5) begin n_fail++; $display("FAIL st_pc_next: got %0d want 5", bus.imem_addr); end
    n_checks++;
    if (dmem[8'h20] !== 8'hA5) begin n_fail++; $display("FAIL st_data: got %0h want a5", dmem[8'h20]); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (dut.regs_q[5] !== 8'hA5) begin n_fail++; $display("FAIL ld_after_st: got %0h want a5", dut.regs_q[5]); end
    n_checks++;
    if (bus.imem_addr !== 10'd6) begin n_fail++; $display("FAIL ld_pc_next: got %0d want 6", bus.imem_addr); end
    $display("test_store_load: done");
  endtask

  task automatic test_shl();
    enter_reset();
    poke(8'h00, 8'h81);
    imem[0] = enc(OP_LD, 3'd1, 3'd0);
    imem[1] = enc(OP_SYS, 3'd0, SUB_CLC);
    imem[2] = enc(OP_SHL, 3'd1, 3'd0);
    imem[3] = enc(OP_SHL, 3'd1, 3'd0);
    release_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if ({dut.sc_q, dut.regs_q[1]} !== 9'h102) begin
      n_fail++; $display("FAIL shl_first: got sc=%b r1=%0h want sc=1 r1=02", dut.sc_q, dut.regs_q[1]);
    end
    @(negedge clk);
    n_checks++;
    if ({dut.sc_q, dut.regs_q[1]} !== 9'h005) begin
      n_fail++; $display("FAIL shl_second: got sc=%b r1=%0h want sc=0 r1=05", dut.sc_q, dut.regs_q[1]);
    end
    $display("test_shl: done");
  endtask

  task automatic test_pc_wrap();
    enter_reset();
    imem[(1<<PCW)-1] = enc(OP_BZ, 3'd0, 3'd1);
    release_reset();
    repeat ((1<<PCW)-1) @(negedge clk);
    n_checks++;
    if (bus.imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL pc_at_top: got %0d want 1023", bus.imem_addr); end
    @(negedge clk);
    n_checks++;
    if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL bz_taken_wrap: got %0d want 0", bus.imem_addr); end

    enter_reset();
    imem[(1<<PCW)-1] = enc(OP_BZ, 3'd0, 3'd2);
    release_reset();
    repeat (1<<PCW) @(negedge clk);
    n_checks++;
    if (bus.imem_addr !== 10'd1) begin n_fail++; $display("FAIL bz_taken_wrap2: got %0d want 1", bus.imem_addr); end

    enter_reset();
    imem[0] = enc(OP_SYS, 3'd0, SUB_SETC);
    imem[1] = enc(OP_ADC, 3'd1, 3'd1);
    imem[(1<<PCW)-1] = enc(OP_BZ, 3'd1, 3'd3);
    release_reset();
    repeat (1<<PCW) @(negedge clk);
    n_checks++;
    if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL bz_untaken_wrap: got %0d want 0", bus.imem_addr); end
    $display("test_pc_wrap: done");
  endtask

  task automatic test_bz_spin_sat();
    enter_reset();
    imem[0] = enc(OP_BZ, 3'd0, 3'd0);
    release_reset();
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL bz_spin_pc: got %0d want 0", bus.imem_addr); end
    n_checks++;
    if (instr_ct !== (PERF ? 4'd15 : 4'd0)) begin
      n_fail++; $display("FAIL instr_ct_sat: got %0d want %0d", instr_ct, PERF ? 15 : 0);
    end
    n_checks++;
    if (cycle_ct !== (PERF ? 4'd15 : 4'd0)) begin
      n_fail++; $display("FAIL cycle_ct_sat: got %0d want %0d", cycle_ct, PERF ? 15 : 0);
    end
    $display("test_bz_spin_sat: done");
  endtask

  task automatic test_reset_mid_mem();
    enter_reset();
    poke(8'h00, 8'h00);
    ack_wait = 1000;
    imem[0] = enc(OP_SYS, 3'd0, SUB_SETC);
    imem[1] = enc(OP_ADC, 3'd1, 3'd1);
    imem[2] = enc(OP_ST, 3'd1, 3'd0);
    release_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL mem_req_wait: got %b want 1", bus.dmem_req); end
    start_n = 1'b0;
    #1;
    n_checks++;
    if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL req_async_drop: got %b want 0", bus.dmem_req); end
    n_checks++;
    if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL pc_async_reset: got %0d want 0", bus.imem_addr); end
    ack_wait = 0;
    release_reset();
    n_checks++;
    if (dut.regs_q[1] !== 8'h00) begin n_fail++; $display("FAIL regs_after_reset: got %0h want 00", dut.regs_q[1]); end
    n_checks++;
    if (dmem[0] !== 8'h00) begin n_fail++; $display("FAIL no_store_on_reset: got %0h want 00", dmem[0]); end
    $display("test_reset_mid_mem: done");
  endtask

  task automatic test_halt();
    enter_reset();
    poke(8'h01, 8'h3C);
    imem[0] = enc(OP_SYS, 3'd0, SUB_SETC);
    imem[1] = enc(OP_ADC, 3'd1, 3'd1);
    imem[2] = enc(OP_XOR, 3'd2, 3'd1);
    imem[3] = enc(OP_ADD, 3'd3, 3'd1);
    imem[4] = enc(OP_SYS, 3'd0, SUB_CLC);
    imem[5] = enc(OP_LD, 3'd4, 3'd1);
    imem[6] = enc(OP_SYS, 3'd0, SUB_HALT);
    release_reset();
    repeat (7) @(negedge clk);
    n_checks++;
    if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_not_yet: got %b want 0", halt); end
    @(negedge clk);
    n_checks++;
    if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", halt); end
    n_checks++;
    if (instr_ct !== (PERF ? 4'd7 : 4'd0)) begin
      n_fail++; $display("FAIL halt_instr_ct: got %0d want %0d", instr_ct, PERF ? 7 : 0);
    end
    n_checks++;
    if (dut.regs_q[4] !== 8'h3C) begin n_fail++; $display("FAIL ld_before_halt: got %0h want 3c", dut.regs_q[4]); end
    n_checks++;
    if (dut.regs_q[2] !== 8'h01) begin n_fail++; $display("FAIL xor_result: got %0h want 01", dut.regs_q[2]); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", halt); end
    n_checks++;
    if (bus.imem_addr !== 10'd6) begin n_fail++; $display("FAIL pc_halt_hold: got %0d want 6", bus.imem_addr); end
    n_checks++;
    if (cycle_ct !== (PERF ? 4'd8 : 4'd0)) begin
      n_fail++; $display("FAIL cycle_ct_frozen: got %0d want %0d", cycle_ct, PERF ? 8 : 0);
    end
    $display("test_halt: done");
  endtask

  initial begin
    test_reset();
    test_add_bz();
    test_store_load();
    test_shl();
    test_pc_wrap();
    test_bz_spin_sat();
    test_reset_mid_mem();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
